// File: rtl/painterengine_gpu_framestreamer.sv
// painterengine_gpu_framestreamer
// Walks a clipped framebuffer rectangle line by line and issues bounded
// DMA reader bursts, each gated on free space in the downstream pixel FIFO.
//
// Ports:
//   i_wire_clock, i_wire_reset      clock, async active-high reset
//   i_wire_start / i_wire_stop      start pulse (latches config) / stop level
//   i_wire_image_address/_stride    frame base byte address, line stride
//   i_wire_clip_width/_height       pixels per line, lines per frame
//   i_wire_half_word                1 = 16bpp packed (2 pixels per word)
//   i_wire_fifo_free_count          free word slots downstream
//   o_wire_reader_address/_length   burst byte address / length in words
//   o_wire_reader_resetn            reader enable, high only while streaming
//   i_wire_reader_done/_error       burst completion / failure
//   o_wire_frame_done               one-cycle pulse at frame end
//   o_wire_busy, o_wire_state       activity flag, {28'd0, error_flag, state}
//
// Optional feature macro: PAINTERENGINE_GPU_FRAMESTREAMER_LOOP_EN
//   defined   -> continuous frame looping with config reload at frame end
//   undefined -> one-shot frames
module painterengine_gpu_framestreamer #(
    parameter int unsigned BURST_WORDS = 32,
    parameter int unsigned FREE_WIDTH  = 8
) (
    input  logic                  i_wire_clock,
    input  logic                  i_wire_reset,
    input  logic                  i_wire_start,
    input  logic                  i_wire_stop,
    input  logic [31:0]           i_wire_image_address,
    input  logic [31:0]           i_wire_image_stride,
    input  logic [15:0]           i_wire_clip_width,
    input  logic [15:0]           i_wire_clip_height,
    input  logic                  i_wire_half_word,
    input  logic [FREE_WIDTH-1:0] i_wire_fifo_free_count,
    output logic [31:0]           o_wire_reader_address,
    output logic [31:0]           o_wire_reader_length,
    output logic                  o_wire_reader_resetn,
    input  logic                  i_wire_reader_done,
    input  logic                  i_wire_reader_error,
    output logic                  o_wire_frame_done,
    output logic                  o_wire_busy,
    output logic [31:0]           o_wire_state
);

    localparam int unsigned CMP_W = (FREE_WIDTH > 32) ? FREE_WIDTH : 32;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CALC       = 3'd1,
        ST_WAIT_SPACE = 3'd2,
        ST_STREAM     = 3'd3,
        ST_CHECK      = 3'd4,
        ST_DONE       = 3'd5,
        ST_ERROR      = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] stride_q, stride_d;
    logic [15:0] height_q, height_d;
    logic [15:0] line_words_q, line_words_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [31:0] line_base_q, line_base_d;
    logic        error_q, error_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] len_q, len_d;
    logic        resetn_q, resetn_d;
    logic        frame_done_q, frame_done_d;
    logic        busy_q, busy_d;

    // Config decode shared by start and loop reload
    logic [15:0] cfg_line_words_c;
    logic        cfg_empty_c;
    logic        load_c;
    logic [15:0] remaining_c;
    logic        space_ok_c;
    logic        line_end_c;
    logic        frame_end_c;

    assign cfg_line_words_c = i_wire_half_word ?
                              16'((17'(i_wire_clip_width) + 17'd1) >> 1) :
                              i_wire_clip_width;
    assign cfg_empty_c      = (i_wire_clip_width == 16'd0) || (i_wire_clip_height == 16'd0);
    assign remaining_c      = line_words_q - x_q;
    assign space_ok_c       = CMP_W'(i_wire_fifo_free_count) >= CMP_W'(len_q);
    assign line_end_c       = (x_q == line_words_q);
    assign frame_end_c      = line_end_c && ((17'(y_q) + 17'd1) == 17'(height_q));

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        stride_d     = stride_q;
        height_d     = height_q;
        line_words_d = line_words_q;
        x_d          = x_q;
        y_d          = y_q;
        line_base_d  = line_base_q;
        error_d      = error_q;
        addr_d       = addr_q;
        len_d        = len_q;
        frame_done_d = 1'b0;
        load_c       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_wire_start) begin
                    load_c  = 1'b1;
                    state_d = cfg_empty_c ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (i_wire_stop) begin
                    state_d = ST_IDLE;
                end else begin
                    addr_d  = line_base_q + 32'({x_q, 2'b00});
                    len_d   = (32'(remaining_c) > 32'(BURST_WORDS)) ?
                              32'(BURST_WORDS) : 32'(remaining_c);
                    state_d = ST_WAIT_SPACE;
                end
            end
            ST_WAIT_SPACE: begin
                if (i_wire_stop) begin
                    state_d = ST_IDLE;
                end else if (space_ok_c) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // error outranks done, and also outranks a pending stop
                if (i_wire_reader_error) begin
                    error_d = 1'b1;
                    state_d = ST_ERROR;
                end else if (i_wire_reader_done) begin
                    x_d     = x_q + 16'(len_q);
                    state_d = i_wire_stop ? ST_IDLE : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (line_end_c) begin
                    x_d         = 16'd0;
                    y_d         = y_q + 16'd1;
                    line_base_d = line_base_q + stride_q;
                end
                if (frame_end_c) begin
                    frame_done_d = 1'b1;
`ifdef PAINTERENGINE_GPU_FRAMESTREAMER_LOOP_EN
                    load_c  = 1'b1;
                    state_d = i_wire_stop ? ST_IDLE :
                              (cfg_empty_c ? ST_DONE : ST_CALC);
`else
                    state_d = i_wire_stop ? ST_IDLE : ST_DONE;
`endif
                end else begin
                    state_d = i_wire_stop ? ST_IDLE : ST_CALC;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Config latch overrides the line/position updates above
        if (load_c) begin
            stride_d     = i_wire_image_stride;
            height_d     = i_wire_clip_height;
            line_words_d = cfg_line_words_c;
            line_base_d  = i_wire_image_address;
            x_d          = 16'd0;
            y_d          = 16'd0;
            error_d      = 1'b0;
        end

        resetn_d = (state_d == ST_STREAM);
        busy_d   = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERROR));
    end

    // State and datapath registers
    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) begin
            state_q      <= ST_IDLE;
            stride_q     <= 32'd0;
            height_q     <= 16'd0;
            line_words_q <= 16'd0;
            x_q          <= 16'd0;
            y_q          <= 16'd0;
            line_base_q  <= 32'd0;
            error_q      <= 1'b0;
            addr_q       <= 32'd0;
            len_q        <= 32'd0;
            resetn_q     <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            stride_q     <= stride_d;
            height_q     <= height_d;
            line_words_q <= line_words_d;
            x_q          <= x_d;
            y_q          <= y_d;
            line_base_q  <= line_base_d;
            error_q      <= error_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            resetn_q     <= resetn_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign o_wire_reader_address = addr_q;
    assign o_wire_reader_length  = len_q;
    assign o_wire_reader_resetn  = resetn_q;
    assign o_wire_frame_done     = frame_done_q;
    assign o_wire_busy           = busy_q;
    assign o_wire_state          = {28'd0, error_q, 3'(state_q)};

endmodule

// File: tb/tb_painterengine_gpu_framestreamer.sv
// Self-checking bench: directed cases plus randomized frames checked against
// a burst-list model computed directly from frame geometry.
module tb_painterengine_gpu_framestreamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] img_addr = 32'd0;
    logic [31:0] img_stride = 32'd0;
    logic [15:0] clip_w = 16'd0;
    logic [15:0] clip_h = 16'd0;
    logic        half_word = 1'b0;
    logic [7:0]  free_cnt = 8'd0;
    logic        rd_done = 1'b0;
    logic        rd_err = 1'b0;
    logic [31:0] rd_addr;
    logic [31:0] rd_len;
    logic        rd_resetn;
    logic        frame_done;
    logic        busy;
    logic [31:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    painterengine_gpu_framestreamer #(.BURST_WORDS(32), .FREE_WIDTH(8)) dut (
        .i_wire_clock          (clk),
        .i_wire_reset          (rst),
        .i_wire_start          (start),
        .i_wire_stop           (stop),
        .i_wire_image_address  (img_addr),
        .i_wire_image_stride   (img_stride),
        .i_wire_clip_width     (clip_w),
        .i_wire_clip_height    (clip_h),
        .i_wire_half_word      (half_word),
        .i_wire_fifo_free_count(free_cnt),
        .o_wire_reader_address (rd_addr),
        .o_wire_reader_length  (rd_len),
        .o_wire_reader_resetn  (rd_resetn),
        .i_wire_reader_done    (rd_done),
        .i_wire_reader_error   (rd_err),
        .o_wire_frame_done     (frame_done),
        .o_wire_busy           (busy),
        .o_wire_state          (state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_resetn"}, 32'(rd_resetn), 32'd0);
        check_eq({tag, "_addr"}, rd_addr, 32'd0);
        check_eq({tag, "_len"}, rd_len, 32'd0);
        check_eq({tag, "_fdone"}, 32'(frame_done), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_state"}, state, 32'd0);
    endtask

    task automatic pulse_start(input logic [31:0] base, input logic [31:0] strd,
                               input logic [15:0] wd, input logic [15:0] ht, input logic hw);
        @(negedge clk);
        img_addr = base; img_stride = strd; clip_w = wd; clip_h = ht; half_word = hw;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one frame with a reactive reader; err_at selects the burst that fails (-1: none)
    task automatic run_frame(input logic [31:0] base, input logic [31:0] strd,
                             input logic [15:0] wd, input logic [15:0] ht, input logic hw,
                             input int err_at, input bit rnd_free);
        logic [31:0] ea[$];
        logic [31:0] el[$];
        int lw, nb, k, fd, hold, gap;
        bit in_b, fin, err_eff;
        logic [31:0] a, l;
        logic [7:0] pf;

        lw = hw ? (int'(wd) + 1) / 2 : int'(wd);
        for (int yy = 0; yy < int'(ht); yy++) begin
            int xx = 0;
            while (xx < lw) begin
                int ln = (lw - xx > 32) ? 32 : lw - xx;
                ea.push_back(base + 32'(yy) * strd + 32'(xx) * 32'd4);
                el.push_back(32'(ln));
                xx += ln;
            end
        end
        nb = ea.size();
        err_eff = (err_at >= 0) && (err_at < nb);

        free_cnt = 8'd255;
        pf = 8'd255;
        pulse_start(base, strd, wd, ht, hw);
        check_eq("lat_calc", state, (wd == 0 || ht == 0) ? 32'd5 : 32'd1);

        k = 0; fd = 0; hold = 0; gap = 0; in_b = 0; fin = 0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            if (frame_done) fd++;
            if (rd_resetn) begin
                rd_done = 1'b0; rd_err = 1'b0;
                if (!in_b) begin
                    in_b = 1; a = rd_addr; l = rd_len;
                    if (k >= nb) begin
                        check_eq("extra_burst", 32'(k), 32'(nb));
                    end else begin
                        check_eq("burst_addr", rd_addr, ea[k]);
                        check_eq("burst_len", rd_len, el[k]);
                    end
                    check_eq("free_gate", 32'(32'(pf) >= l), 32'd1);
                    if (k > 0) check_eq("gap", 32'(gap >= 3), 32'd1);
                    hold = $urandom_range(0, 3);
                end
                if (hold == 0) begin
                    check_eq("addr_stable", rd_addr, a);
                    check_eq("len_stable", rd_len, l);
                    rd_done = 1'b1;
                    if (k == err_at) begin
                        rd_err = 1'b1;
                        rd_done = 1'($urandom_range(0, 1));
                    end
                    k++;
                end else begin
                    hold--;
                end
            end else begin
                if (in_b) begin in_b = 0; gap = 0; end
                gap++;
                // stray pulses outside a burst must be ignored
                rd_done = ($urandom_range(0, 7) == 0);
                rd_err  = ($urandom_range(0, 15) == 0);
                if (!busy) fin = 1;
            end
            pf = rnd_free ? 8'($urandom_range(0, 255)) : 8'd255;
            free_cnt = pf;
        end
        rd_done = 1'b0; rd_err = 1'b0;

        check_eq("timeout", 32'(fin), 32'd1);
        check_eq("burst_count", 32'(k), err_eff ? 32'(err_at + 1) : 32'(nb));
        check_eq("frame_done_cnt", 32'(fd), (!err_eff && nb > 0) ? 32'd1 : 32'd0);
        check_eq("end_state", state, err_eff ? 32'hF : 32'h5);
        check_eq("end_resetn", 32'(rd_resetn), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

`ifdef PAINTERENGINE_GPU_FRAMESTREAMER_LOOP_EN
        begin
            int fd = 0;
            bit seen = 0;
            free_cnt = 8'd255;
            pulse_start(32'h2000, 32'd64, 16'd1, 16'd1, 1'b0);
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (frame_done) fd++;
                rd_done = rd_resetn;
            end
            rd_done = 1'b0;
            check_eq("loop_fdone", 32'(fd >= 3), 32'd1);
            free_cnt = 8'd0;
            for (int c = 0; c < 50 && !seen; c++) begin
                @(negedge clk);
                if (state == 32'd2) seen = 1;
            end
            check_eq("loop_wait_seen", 32'(seen), 32'd1);
            stop = 1'b1;
            @(negedge clk);
            check_eq("loop_stop_idle", state, 32'd0);
            stop = 1'b0;
        end
`else
        // Directed geometry cases
        run_frame(32'h1000, 32'd256, 16'd64, 16'd2, 1'b0, -1, 1'b0);
        run_frame(32'h1000, 32'd256, 16'd40, 16'd1, 1'b0, -1, 1'b0);
        run_frame(32'h1000, 32'd256, 16'd5, 16'd1, 1'b1, -1, 1'b0);
        run_frame(32'h1000, 32'd256, 16'd0, 16'd3, 1'b0, -1, 1'b0);
        run_frame(32'h1000, 32'd256, 16'd64, 16'd2, 1'b0, 1, 1'b0);
        run_frame(32'h1000, 32'd256, 16'd64, 16'd1, 1'b0, -1, 1'b0);

        // Held in WAIT_SPACE until free space covers the burst, then stop mid-burst
        free_cnt = 8'd10;
        pulse_start(32'h1000, 32'd256, 16'd64, 16'd1, 1'b0);
        repeat (6) @(negedge clk);
        check_eq("ws_state", state, 32'd2);
        check_eq("ws_resetn", 32'(rd_resetn), 32'd0);
        check_eq("ws_len", rd_len, 32'd32);
        check_eq("ws_addr", rd_addr, 32'h1000);
        free_cnt = 8'd32;
        @(negedge clk);
        check_eq("ws_rise", 32'(rd_resetn), 32'd1);
        stop = 1'b1; rd_done = 1'b1;
        @(negedge clk);
        check_eq("stream_stop_state", state, 32'd0);
        check_eq("stream_stop_busy", 32'(busy), 32'd0);
        check_eq("stream_stop_resetn", 32'(rd_resetn), 32'd0);
        stop = 1'b0; rd_done = 1'b0;

        // Stop in CALC
        free_cnt = 8'd0;
        pulse_start(32'h3000, 32'd128, 16'd8, 16'd2, 1'b0);
        check_eq("calc_state", state, 32'd1);
        stop = 1'b1;
        @(negedge clk);
        check_eq("calc_stop", state, 32'd0);
        stop = 1'b0;

        // Stop in WAIT_SPACE
        pulse_start(32'h3000, 32'd128, 16'd8, 16'd2, 1'b0);
        @(negedge clk);
        check_eq("wait_state", state, 32'd2);
        stop = 1'b1;
        @(negedge clk);
        check_eq("wait_stop", state, 32'd0);
        stop = 1'b0;

        // Async reset in the middle of a burst
        free_cnt = 8'd255;
        pulse_start(32'h1000, 32'd256, 16'd64, 16'd1, 1'b0);
        begin
            bit up = 0;
            for (int c = 0; c < 20 && !up; c++) begin
                @(negedge clk);
                if (rd_resetn) up = 1;
            end
            check_eq("rst_pre_stream", 32'(up), 32'd1);
        end
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;

        // Randomized frames, free space and occasional burst errors
        for (int i = 0; i < 25; i++) begin
            logic [31:0] b, s;
            logic [15:0] w, h;
            logic hw;
            int ea;
            b  = $urandom();
            s  = $urandom();
            w  = 16'($urandom_range(0, 100));
            h  = 16'($urandom_range(0, 3));
            hw = 1'($urandom_range(0, 1));
            ea = ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, 3)) : -1;
            run_frame(b, s, w, h, hw, ea, 1'b1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
